pwm_meas: RTL and testbench
===========================

PWM_MEAS -- requirements
Module: pwm_meas

Interface
REQ-001 Parameter CNT_W, default 24, width of all measurement counters and outputs.
REQ-002 Parameter TIMEOUT, default 24'd1500_0000, cycles without a rising edge before timeout (300 ms at 50 MHz); legal range 4..2^CNT_W-1.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 pwm_in  input  1  asynchronous PWM waveform to be measured.
REQ-006 period  output  CNT_W  clk cycles between the last two qualified rising edges.
REQ-007 high_time  output  CNT_W  clk cycles the qualified input was high within that period.
REQ-008 meas_valid  output  1  one-cycle pulse when period/high_time update.
REQ-009 timeout  output  1  level, no rising edge seen for TIMEOUT cycles.

Function
REQ-010 pwm_in SHALL pass through a 2-flop synchronizer; the synchronized signal is the qualified input unless REQ-030 applies.
REQ-011 Rising/falling edges SHALL be detected by comparing the qualified input with its 1-cycle-delayed copy.
REQ-012 FSM states: IDLE, HIGH, LOW; reset state IDLE.
REQ-013 IDLE: wait for a rising edge, then clear cnt_per and cnt_hi to 1 and go to HIGH.
REQ-014 HIGH: cnt_per and cnt_hi increment each cycle; falling edge -> LOW with cnt_hi frozen.
REQ-015 LOW: cnt_per increments each cycle; rising edge -> latch period<=cnt_per, high_time<=cnt_hi, pulse meas_valid, timeout<=0, restart both counters at 1, go to HIGH.
REQ-016 Measured values SHALL equal exact cycle counts: a qualified input with period P and high width H yields period=P, high_time=H.
REQ-017 meas_valid SHALL assert exactly 3 clk cycles after the pwm_in rising edge that closes a period (2 sync + 1 register), filter disabled.
REQ-018 First rising edge after reset or timeout SHALL NOT produce meas_valid; first valid result follows the second rising edge.
REQ-019 In HIGH or LOW, if cnt_per reaches TIMEOUT without a rising edge: timeout<=1, FSM -> IDLE, period/high_time hold last values, no meas_valid.
REQ-020 Constant-high or constant-low input SHALL therefore yield timeout=1 after TIMEOUT cycles; counters never wrap (TIMEOUT < 2^CNT_W).
REQ-021 timeout SHALL remain 1 until the next meas_valid clears it.
REQ-022 Rising edge in the same cycle cnt_per reaches TIMEOUT: the edge wins (measurement completes, no timeout).
REQ-023 Rising edge in HIGH (impossible without a falling edge) SHALL be ignored by construction; falling edge in LOW ignored.

Reset
REQ-024 rstn low SHALL asynchronously force: period=0, high_time=0, meas_valid=0, timeout=0, FSM=IDLE, counters=0, synchronizer and filter flops=0.
REQ-025 Reset asserted mid-measurement SHALL discard the partial measurement; no meas_valid is produced on release.
REQ-026 Outputs SHALL be register-driven only; no combinational path from pwm_in to any output.

Configuration
REQ-030 Macro PWM_MEAS_FILTER_EN defined: a glitch filter after the synchronizer updates the qualified input only after the synchronized input has been stable at a new value for 4 consecutive cycles; pulses shorter than 4 cycles are suppressed; REQ-017 latency becomes 7 cycles; measured P and H are unchanged for pulses >= 4 cycles.
REQ-031 Macro undefined: no filter logic is synthesized; the synchronized input is used directly.

Verification
REQ-040 pwm_in period 100 cycles, high 30, 5 periods -> 4 meas_valid pulses, each with period=100, high_time=30, timeout=0.
REQ-041 TIMEOUT=1000, pwm_in held low 1200 cycles after one rising edge -> timeout=1 at cycle 1000 after edge, period/high_time unchanged, no meas_valid.
REQ-042 After REQ-041, apply period 50 high 25 -> timeout stays 1 until first meas_valid, then timeout=0 with period=50, high_time=25.
REQ-043 2-cycle high glitch inside a 100/30 stream -> with PWM_MEAS_FILTER_EN: results stay 100/30; without: extra short measurement reported.
REQ-044 rstn pulsed low mid-HIGH of a 100/30 stream -> all outputs 0 immediately, no meas_valid until two full rising edges after release, then 100/30.
REQ-045 Duty sweep high_time 1, 99 of period 100 (filter disabled) -> high_time=1 and 99 respectively, period=100.

Source files
------------

// File: rtl/pwm_meas.sv
// pwm_meas: measures period and high time of an asynchronous PWM input in clk cycles.
// Optional glitch filter on the synchronized input is enabled by defining PWM_MEAS_FILTER_EN.
module pwm_meas #(
    parameter int unsigned      CNT_W   = 24,
    parameter logic [CNT_W-1:0] TIMEOUT = 24'd1500_0000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    logic             sync1_r;
    logic             sync2_r;
    logic             qual_s;
    logic             qual_d_r;
    logic [2:0]       settle_r;
    logic             rise_s;
    logic             fall_s;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_per_r;
    logic [CNT_W-1:0] cnt_hi_r;

    // Two-flop synchronizer for the asynchronous PWM input.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pwm_in;
            sync2_r <= sync1_r;
        end
    end

`ifdef PWM_MEAS_FILTER_EN
    // Cycles after reset release until the qualified input and its delayed copy are meaningful.
    localparam logic [2:0] SETTLE = 3'd7;

    logic       filt_r;
    logic [1:0] stab_cnt_r;

    // Glitch filter: accept a new level only after it has been stable for 4 consecutive cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            filt_r     <= 1'b0;
            stab_cnt_r <= 2'd0;
        end else if (sync2_r == filt_r) begin
            stab_cnt_r <= 2'd0;
        end else if (stab_cnt_r == 2'd3) begin
            filt_r     <= sync2_r;
            stab_cnt_r <= 2'd0;
        end else begin
            stab_cnt_r <= stab_cnt_r + 2'd1;
        end
    end

    assign qual_s = filt_r;
`else
    localparam logic [2:0] SETTLE = 3'd3;

    assign qual_s = sync2_r;
`endif

    // Delayed copy for edge detection and a settle counter that masks the pipeline fill after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            qual_d_r <= 1'b0;
            settle_r <= 3'd0;
        end else begin
            qual_d_r <= qual_s;
            if (settle_r != SETTLE) begin
                settle_r <= settle_r + 3'd1;
            end else begin
                settle_r <= settle_r;
            end
        end
    end

    // Edge detection; a level already present at reset release must not look like an edge.
    always_comb begin
        rise_s = 1'b0;
        fall_s = 1'b0;
        if (settle_r == SETTLE) begin
            rise_s = qual_s & ~qual_d_r;
            fall_s = ~qual_s & qual_d_r;
        end else begin
            rise_s = 1'b0;
            fall_s = 1'b0;
        end
    end

    // Measurement FSM with registered results, valid pulse and timeout level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            cnt_per_r  <= '0;
            cnt_hi_r   <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rise_s) begin
                        cnt_per_r <= CNT_ONE;
                        cnt_hi_r  <= CNT_ONE;
                        state_r   <= ST_HIGH;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_HIGH: begin
                    if (cnt_per_r == TIMEOUT) begin
                        timeout <= 1'b1;
                        state_r <= ST_IDLE;
                    end else if (fall_s) begin
                        cnt_per_r <= cnt_per_r + CNT_ONE;
                        state_r   <= ST_LOW;
                    end else begin
                        cnt_per_r <= cnt_per_r + CNT_ONE;
                        cnt_hi_r  <= cnt_hi_r + CNT_ONE;
                    end
                end
                ST_LOW: begin
                    // A rising edge in the same cycle as the limit still completes the measurement.
                    if (rise_s) begin
                        period     <= cnt_per_r;
                        high_time  <= cnt_hi_r;
                        meas_valid <= 1'b1;
                        timeout    <= 1'b0;
                        cnt_per_r  <= CNT_ONE;
                        cnt_hi_r   <= CNT_ONE;
                        state_r    <= ST_HIGH;
                    end else if (cnt_per_r == TIMEOUT) begin
                        timeout <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_per_r <= cnt_per_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_meas.sv
// Directed self-checking bench for pwm_meas: streams, timeout, recovery, glitch, duty sweep, reset.
module tb_pwm_meas;

    localparam int TO = 1000;
`ifdef PWM_MEAS_FILTER_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        pwm_in;
    logic [23:0] period;
    logic [23:0] high_time;
    logic        meas_valid;
    logic        timeout;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] q_per[$];
    logic [31:0] q_hi[$];
    logic [31:0] q_to[$];

    pwm_meas #(.CNT_W(24), .TIMEOUT(24'd1000)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .pwm_in     (pwm_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Record every reported measurement.
    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            q_per.push_back(32'(period));
            q_hi.push_back(32'(high_time));
            q_to.push_back(32'(timeout));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int h, input int l);
        pwm_in = 1'b1;
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic clear_q();
        q_per.delete();
        q_hi.delete();
        q_to.delete();
    endtask

    task automatic chk_q(input string tag, input int n, input int per[], input int hi[]);
        chk({tag, "_count"}, q_per.size(), n);
        for (int i = 0; i < n && i < q_per.size(); i++) begin
            chk({tag, "_per"}, q_per[i], per[i]);
            chk({tag, "_hi"},  q_hi[i],  hi[i]);
            chk({tag, "_to"},  q_to[i],  0);
        end
    endtask

    initial begin
        rstn   = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_period", period, 0);
        chk("rst_high", high_time, 0);
        chk("rst_valid", meas_valid, 0);
        chk("rst_timeout", timeout, 0);
        rstn = 1'b1;
        repeat (10) @(negedge clk);

        // 100/30 stream, exact latency of the closing edge, then timeout with held results.
        clear_q();
        repeat (4) pulse(30, 70);
        pwm_in = 1'b1;
        for (int j = 1; j <= 1200; j++) begin
            @(negedge clk);
            if (j == 30) pwm_in = 1'b0;
            if (j == LAT - 1) chk("lat_before", meas_valid, 0);
            if (j == LAT) begin
                chk("lat_valid", meas_valid, 1);
                chk("lat_period", period, 100);
                chk("lat_high", high_time, 30);
            end
            if (j == TO + LAT - 1) chk("to_before", timeout, 0);
            if (j == TO + LAT) begin
                chk("to_set", timeout, 1);
                chk("to_no_valid", meas_valid, 0);
            end
        end
        chk("to_hold_period", period, 100);
        chk("to_hold_high", high_time, 30);
        chk("to_level", timeout, 1);
        chk_q("stream100", 4, '{100, 100, 100, 100}, '{30, 30, 30, 30});

        // Recovery with 50/25: timeout stays until the first valid result.
        clear_q();
        pulse(25, 25);
        chk("rec_to_held", timeout, 1);
        pwm_in = 1'b1;
        for (int j = 1; j <= 50; j++) begin
            @(negedge clk);
            if (j == 25) pwm_in = 1'b0;
            if (j == LAT - 1) begin
                chk("rec_to_before", timeout, 1);
                chk("rec_valid_before", meas_valid, 0);
            end
            if (j == LAT) begin
                chk("rec_valid", meas_valid, 1);
                chk("rec_to_clear", timeout, 0);
                chk("rec_period", period, 50);
                chk("rec_high", high_time, 25);
            end
        end
        repeat (2) pulse(25, 25);
        pulse(25, 1100);
        chk_q("stream50", 4, '{50, 50, 50, 50}, '{25, 25, 25, 25});

        // Two-cycle glitch inside the low phase of a 100/30 stream.
        clear_q();
        pulse(30, 70);
        pulse(30, 70);
        pulse(30, 20);
        pulse(2, 48);
        pulse(30, 70);
        pulse(30, 1100);
`ifdef PWM_MEAS_FILTER_EN
        chk_q("glitch", 4, '{100, 100, 100, 100}, '{30, 30, 30, 30});
`else
        chk_q("glitch", 5, '{100, 100, 50, 50, 100}, '{30, 30, 30, 2, 30});

        // Duty extremes of a 100-cycle period.
        clear_q();
        pulse(1, 99);
        pulse(1, 99);
        pulse(99, 1);
        pulse(99, 1);
        pulse(30, 1100);
        chk_q("duty", 4, '{100, 100, 100, 100}, '{1, 1, 99, 99});
`endif

        // Reset in the middle of a high phase discards the partial measurement.
        clear_q();
        pulse(30, 70);
        pulse(30, 70);
        pwm_in = 1'b1;
        repeat (10) @(negedge clk);
        chk("pre_rst_count", q_per.size(), 2);
        chk("pre_rst_period", period, 100);
        #3 rstn = 1'b0;
        #1;
        chk("mid_rst_period", period, 0);
        chk("mid_rst_high", high_time, 0);
        chk("mid_rst_valid", meas_valid, 0);
        chk("mid_rst_timeout", timeout, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (18) @(negedge clk);
        pwm_in = 1'b0;
        repeat (70) @(negedge clk);
        clear_q();
        pulse(30, 70);
        chk("post_rst_first_edge", q_per.size(), 0);
        pulse(30, 70);
        pulse(30, 1100);
        chk_q("post_rst", 2, '{100, 100}, '{30, 30});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
